// File: rtl/mcycle_unit.sv
// Iterative multiply/divide engine for the execute stage.
// One shift-add or restoring shift-subtract step per cycle, WIDTH steps per operation.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             sign1;
  logic             sign2;
  logic             div_zero;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   hi_nx;
  logic [WIDTH-1:0] lo_nx;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted_r;
  logic [WIDTH+1:0] diff;
  logic [2*WIDTH:0] mul_shift;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res1_nx;
  logic [WIDTH-1:0] res2_nx;

  // Magnitudes only for signed ops (MCycleOp[0] == 0); the negation wraps at WIDTH bits.
  always_comb begin
    mag1 = (!MCycleOp[0] && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
    mag2 = (!MCycleOp[0] && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
  end

  // hi:lo is the product for multiply, remainder:quotient for divide.
  always_comb begin
    sum       = lo[0] ? (hi + {1'b0, opnd}) : hi;
    mul_shift = {sum, lo} >> 1;
    shifted_r = {hi[WIDTH-1:0], lo[WIDTH-1]};
    diff      = {1'b0, shifted_r} - {2'b00, opnd};
    hi_nx     = hi;
    lo_nx     = lo;
    if (!is_div) begin
      hi_nx = mul_shift[2*WIDTH:WIDTH];
      lo_nx = mul_shift[WIDTH-1:0];
    end else if (!diff[WIDTH+1]) begin
      hi_nx = diff[WIDTH:0];
      lo_nx = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = shifted_r;
      lo_nx = {lo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    prod    = {hi_nx[WIDTH-1:0], lo_nx};
    res1_nx = '0;
    res2_nx = '0;
    if (!is_div) begin
      if (sign1 ^ sign2) prod = -prod;
      res1_nx = prod[WIDTH-1:0];
      res2_nx = prod[2*WIDTH-1:WIDTH];
    end else begin
      res1_nx = (sign1 ^ sign2) ? -lo_nx : lo_nx;
      res2_nx = sign1 ? -hi_nx[WIDTH-1:0] : hi_nx[WIDTH-1:0];
      // Divide by zero: the remainder path already reproduces Operand1.
      if (div_zero) res1_nx = '1;
    end
  end

  always_comb begin
    unique case (state)
      IDLE:      Busy = Start;
      COMPUTING: Busy = 1'b1;
      default:   Busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      Result1  <= '0;
      Result2  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            is_div   <= MCycleOp[1];
            sign1    <= !MCycleOp[0] && Operand1[WIDTH-1];
            sign2    <= !MCycleOp[0] && Operand2[WIDTH-1];
            div_zero <= (Operand2 == '0);
            hi       <= '0;
            lo       <= MCycleOp[1] ? mag1 : mag2;
            opnd     <= MCycleOp[1] ? mag2 : mag1;
            count    <= '0;
            state    <= COMPUTING;
          end
        end
        COMPUTING: begin
          hi    <= hi_nx;
          lo    <= lo_nx;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            Result1 <= res1_nx;
            Result2 <= res2_nx;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed vector table, random ops against
// an arithmetic reference model, and hand sequences for stall/reset corners.
module tb_mcycle_unit;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1;
  logic [W-1:0] Operand2;
  logic [W-1:0] Result1;
  logic [W-1:0] Result2;
  logic         Busy;

  int checks   = 0;
  int failures = 0;

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r1, output logic [W-1:0] r2);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    int unsigned     ua, ub;
    sa = a; sb = b; ua = a; ub = b;
    r1 = '0; r2 = '0;
    case (op)
      2'b00: begin sp = longint'(sa) * longint'(sb); {r2, r1} = sp; end
      2'b01: begin up = longint'(ua) * longint'(ub); {r2, r1} = up; end
      default: begin
        if (b == 0) begin
          r1 = '1; r2 = a;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r1 = 32'h8000_0000; r2 = 0;
        end else if (op == 2'b10) begin
          r1 = sa / sb; r2 = sa % sb;
        end else begin
          r1 = ua / ub; r2 = ua % ub;
        end
      end
    endcase
  endtask

  // Launch one op with a single-cycle Start; return Busy length. Ends in the DONE cycle.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1;
    lat = 0;
    while (Busy && lat < 200) begin
      lat++;
      @(negedge CLK);
      Start = 1'b0;
      Operand1 = $urandom;
      Operand2 = $urandom;
      MCycleOp = 2'($urandom_range(0, 3));
      #1;
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] specials[6];
    specials[0] = 0; specials[1] = 1; specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF; specials[5] = 7;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    int           lat;
    logic [W-1:0] e1, e2, a, b;
    logic [1:0]   op;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF};
    vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[4] = '{2'b11, 32'd100,       32'd7,         32'd14,        32'd2};
    vecs[5] = '{2'b11, 32'd100,       32'd0,         32'hFFFF_FFFF, 32'd100};
    vecs[6] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    vecs[8] = '{2'b01, 32'd6,         32'd7,         32'd42,        32'd0};
    vecs[9] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};

    RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_r1", 64'(Result1), 64'd0);
    chk("reset_r2", 64'(Result2), 64'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(W + 1));
      chk($sformatf("vec%0d_r1", i), 64'(Result1), 64'(vecs[i].r1));
      chk($sformatf("vec%0d_r2", i), 64'(Result2), 64'(vecs[i].r2));
    end

    // Results hold through idle cycles.
    repeat (3) @(negedge CLK);
    #1;
    chk("hold_r1", 64'(Result1), 64'(vecs[9].r1));
    chk("hold_r2", 64'(Result2), 64'(vecs[9].r2));

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      model(op, a, b, e1, e2);
      do_op(op, a, b, lat);
      chk($sformatf("rnd%0d_op%0d_latency", i, op), 64'(lat), 64'(W + 1));
      chk($sformatf("rnd%0d_op%0d_r1 a=%0h b=%0h", i, op, a, b), 64'(Result1), 64'(e1));
      chk($sformatf("rnd%0d_op%0d_r2 a=%0h b=%0h", i, op, a, b), 64'(Result2), 64'(e2));
    end

    // Start held high through DONE, operands changed mid-computation.
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd6; Operand2 = 32'd7;
    #1;
    lat = 0;
    while (Busy && lat < 200) begin
      lat++;
      @(negedge CLK);
      if (lat == 5) begin Operand1 = 32'd100; MCycleOp = 2'b11; end
      #1;
    end
    chk("held_latency", 64'(lat), 64'(W + 1));
    chk("held_done_busy", 64'(Busy), 64'd0);
    chk("held_r1", 64'(Result1), 64'd42);
    chk("held_r2", 64'(Result2), 64'd0);
    @(negedge CLK);
    MCycleOp = 2'b01;
    #1;
    chk("held_relaunch_busy", 64'(Busy), 64'd1);
    lat = 0;
    while (Busy && lat < 200) begin
      lat++;
      @(negedge CLK);
      Start = 1'b0;
      #1;
    end
    chk("second_latency", 64'(lat), 64'(W + 1));
    chk("second_r1", 64'(Result1), 64'd700);
    chk("second_r2", 64'(Result2), 64'd0);

    // Reset during iteration 10 of a multiply.
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd1234; Operand2 = 32'd5678;
    @(negedge CLK);
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    #1;
    chk("midop_busy", 64'(Busy), 64'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_r1", 64'(Result1), 64'd0);
    chk("abort_r2", 64'(Result2), 64'd0);

    // Reset and Start together: nothing is captured.
    @(negedge CLK);
    RESET = 1'b1; Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd9; Operand2 = 32'd9;
    @(negedge CLK);
    RESET = 1'b0; Start = 1'b0;
    #1;
    chk("rst_start_busy", 64'(Busy), 64'd0);
    @(negedge CLK);
    #1;
    chk("rst_start_busy2", 64'(Busy), 64'd0);

    do_op(2'b01, 32'd6, 32'd7, lat);
    chk("post_reset_latency", 64'(lat), 64'(W + 1));
    chk("post_reset_r1", 64'(Result1), 64'd42);
    chk("post_reset_r2", 64'(Result2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
Iterative multi-cycle multiply/divide engine that serves the execute stage. It consumes the E-stage MCycleStartE/MCycleOpE/operand signals and produces the Busy signal that stalls the ID/EX register and upstream stages. It returns a 2×WIDTH product, or a quotient and remainder. It sits beside the ALU, and its results are selected into the E-stage compute result.

Parameters:
WIDTH, 32, operand width; also the iteration count.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous active-high reset
Start  in  1  request from E stage (MCycleStartE)
MCycleOp  in  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
Operand1  in  WIDTH  multiplicand / dividend (forwarded rs1 value)
Operand2  in  WIDTH  multiplier / divisor (forwarded rs2 value)
Result1  out  WIDTH  low product word / quotient
Result2  out  WIDTH  high product word / remainder
Busy  out  1  stall request to pipeline

Behaviour:
- Single clock, CLK. RESET is synchronous and active-high.
- Reset state: IDLE, iteration counter 0, internal accumulators 0, Result1 = 0, Result2 = 0, Busy = 0.
- FSM states:
  - IDLE: Busy = Start (combinational). When Start = 1, at the next edge:
    - latch MCycleOp;
    - latch the operand sign flags;
    - latch |Operand1| and |Operand2| (absolute values only for signed ops; raw values for unsigned ops);
    - clear the counter and go to COMPUTING.
  - COMPUTING: Busy = 1.
    - Performs one shift-add (mul) or one restoring shift-subtract (div) step per cycle.
    - Runs exactly WIDTH iterations, with the counter running 0..WIDTH-1.
    - At the edge that ends iteration WIDTH-1: apply sign correction, register Result1/Result2, go to DONE.
  - DONE: Busy = 0 and Start is ignored, even though it is still high while the E register advances. Next edge goes to IDLE.
- Latency: with Start high in cycle 0, Busy is high in cycles 0..WIDTH (WIDTH+1 cycles). DONE is cycle WIDTH+1, where Busy = 0 and the results are valid.
- Result hold: Result1/Result2 hold their value until the next DONE. They are not cleared in IDLE.
- Operand changes and Start toggles after capture (during COMPUTING) are ignored.
- MCycleOp changes after capture are ignored.
- Multiply:
  - Unsigned 2W-bit product of the captured magnitudes.
  - Signed op: negate the 2W-bit product (two's complement) iff the operand signs differ.
  - Result1 = product[W-1:0], Result2 = product[2W-1:W].
- Divide:
  - Unsigned restoring division of the magnitudes.
  - Signed op: negate the quotient iff the signs differ; the remainder takes the dividend's sign.
  - Invariant: dividend = quotient*divisor + remainder.
- Divide by zero (divisor captured as 0): Result1 = all ones and Result2 = original Operand1, for both signed and unsigned. This overrides sign correction. Iteration still runs WIDTH cycles, so the latency is unchanged.
- Signed overflow (most-negative / -1): Result1 = most-negative value, Result2 = 0. This falls out of the magnitude datapath, provided the magnitudes are held at W bits unsigned and the negation wraps.
- RESET in any state, including mid-COMPUTING: next state IDLE, results 0, Busy = 0 in the following cycle. The in-flight operation is abandoned.
- Start high in the same cycle as RESET: RESET wins and nothing is captured.
- Back-to-back operations: a new Start is accepted only from IDLE. Minimum spacing is WIDTH+2 cycles between accepted Starts.
- Busy has no combinational path from the operands, only from Start and the state.

Test Plan:
- Unsigned mul (op 01) of 0xFFFFFFFF by 0xFFFFFFFF → Busy high for 33 cycles, then DONE with Result1 = 0x00000001, Result2 = 0xFFFFFFFE.
- Signed mul (op 00) of -3 by 7 → Result1 = 0xFFFFFFEB, Result2 = 0xFFFFFFFF; then 0x80000000 × 0x80000000 → Result1 = 0x00000000, Result2 = 0x40000000.
- Signed div (op 10) of -7 by 2 → Result1 = 0xFFFFFFFD, Result2 = 0xFFFFFFFF; unsigned div (op 11) of 100 by 7 → Result1 = 14, Result2 = 2.
- Divide by zero, op 11 with 100/0 and op 10 with -5/0 → Result1 = 0xFFFFFFFF; Result2 = 100 and 0xFFFFFFFB respectively. Signed overflow 0x80000000 / 0xFFFFFFFF → Result1 = 0x80000000, Result2 = 0.
- Hold Start high through DONE (pipeline-stall model), then change the operands mid-COMPUTING → exactly one operation runs and the results reflect the captured operands. Start in the cycle after DONE launches the second operation.
- Assert RESET at iteration 10 of a mul → IDLE next cycle, with Busy = 0 and Result1/Result2 = 0. A subsequent 6×7 mul → Result1 = 42, Result2 = 0.
